// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite transfer/burst encodings and burst-length helper for the bus arbiter.
// Consumed by ahb_bus_arbiter (optional macro AHB_ARB_FIXED_PRIORITY_EN) and its bench.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  localparam int CNT_W = 5;

  // Remaining SEQ beats after the NONSEQ; undefined-length bursts count as zero.
  function automatic logic [CNT_W-1:0] burst_beats_minus1(input hburst_e hburst);
    case (hburst)
      WRAP4,  INCR4:  return CNT_W'(3);
      WRAP8,  INCR8:  return CNT_W'(7);
      WRAP16, INCR16: return CNT_W'(15);
      default:        return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational circular priority picker: first set request at or after 'start',
// wrapping around; returns a one-hot winner and a valid flag.
module ahb_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [2*N-1:0] req_rot2;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] gnt2;

  // Rotate so 'start' lands on bit 0, pick the lowest set bit, rotate back.
  assign req_rot2 = {req, req} >> start;
  assign rot      = req_rot2[N-1:0];

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    first = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !valid) begin
        first[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

  assign gnt2 = {{N{1'b0}}, first} << start;
  assign gnt  = gnt2[N-1:0] | gnt2[2*N-1:N];

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-Lite bus arbiter: round-robin grant with burst, lock and wait-state awareness.
// Define AHB_ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NO_OF_MANAGERS = 3,
  parameter int MGR_BITS       = 2,
  parameter int PARK_MANAGER   = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NO_OF_MANAGERS-1:0] HBUSREQ,
  input  logic [NO_OF_MANAGERS-1:0] HLOCK,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HBURST,
  input  logic                      HREADY,
  output logic [NO_OF_MANAGERS-1:0] HGRANT,
  output logic [MGR_BITS-1:0]       HMASTER,
  output logic [MGR_BITS-1:0]       HMASTER_DATA,
  output logic                      HMASTLOCK
);

  localparam logic [NO_OF_MANAGERS-1:0] PARK_ONEHOT = NO_OF_MANAGERS'(1) << PARK_MANAGER;
  localparam logic [MGR_BITS-1:0]       PARK_IDX    = MGR_BITS'(PARK_MANAGER);

  function automatic logic [MGR_BITS-1:0] onehot_idx(input logic [NO_OF_MANAGERS-1:0] oh);
    logic [MGR_BITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < NO_OF_MANAGERS; i++)
      if (oh[i]) idx |= MGR_BITS'(i);
    return idx;
  endfunction

  htrans_e                   trans;
  hburst_e                   burst;
  logic [CNT_W-1:0]          beat_cnt;
  logic                      owner_lock;
  logic                      arb_point;
  logic [MGR_BITS-1:0]       search_start;
  logic [NO_OF_MANAGERS-1:0] pick_gnt;
  logic                      pick_valid;
  logic [NO_OF_MANAGERS-1:0] next_gnt;
  logic [MGR_BITS-1:0]       next_idx;

  assign trans      = htrans_e'(HTRANS);
  assign burst      = hburst_e'(HBURST);
  assign owner_lock = HLOCK[HMASTER];

  // The bus may change hands only where no burst or locked sequence would be split.
  assign arb_point = HREADY && !HMASTLOCK && !owner_lock &&
                     ((trans == IDLE) ||
                      (trans == NONSEQ && (burst == SINGLE || burst == INCR)) ||
                      (trans == SEQ && (beat_cnt <= CNT_W'(1) || burst == INCR)));

`ifdef AHB_ARB_FIXED_PRIORITY_EN
  assign search_start = '0;
`else
  logic [MGR_BITS-1:0] rr_ptr;

  assign search_start = (rr_ptr == MGR_BITS'(NO_OF_MANAGERS - 1)) ? '0 : rr_ptr + MGR_BITS'(1);
`endif

  ahb_rr_picker #(
    .N     (NO_OF_MANAGERS),
    .IDX_W (MGR_BITS)
  ) u_picker (
    .req   (HBUSREQ),
    .start (search_start),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign next_gnt = pick_valid ? pick_gnt : PARK_ONEHOT;
  assign next_idx = onehot_idx(next_gnt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT       <= PARK_ONEHOT;
      HMASTER      <= PARK_IDX;
      HMASTER_DATA <= PARK_IDX;
      HMASTLOCK    <= 1'b0;
      beat_cnt     <= '0;
`ifndef AHB_ARB_FIXED_PRIORITY_EN
      rr_ptr       <= PARK_IDX;
`endif
    end else if (HREADY) begin
      HMASTER_DATA <= HMASTER;
      HMASTLOCK    <= owner_lock;
      case (trans)
        NONSEQ:  beat_cnt <= burst_beats_minus1(burst);
        SEQ:     if (beat_cnt != '0) beat_cnt <= beat_cnt - CNT_W'(1);
        default: ;
      endcase
      if (arb_point) begin
        HGRANT  <= next_gnt;
        HMASTER <= next_idx;
`ifndef AHB_ARB_FIXED_PRIORITY_EN
        rr_ptr  <= next_idx;
`endif
      end
    end
  end

  a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(HGRANT));
  a_master_index: assert property (@(posedge HCLK) disable iff (!HRESETn)
                                   HGRANT == (NO_OF_MANAGERS'(1) << HMASTER));
  a_wait_freeze:  assert property (@(posedge HCLK) disable iff (!HRESETn)
                                   !HREADY |=> $stable(HGRANT));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed vectors push hand-computed expectations,
// a monitor compares grant/owner/data-owner/lock one time unit after each rising edge.
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;

  localparam int N = 3;
  localparam int W = 2;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [W-1:0] HMASTER;
  logic [W-1:0] HMASTER_DATA;
  logic         HMASTLOCK;

  ahb_bus_arbiter #(
    .NO_OF_MANAGERS (N),
    .MGR_BITS       (W),
    .PARK_MANAGER   (0)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HBUSREQ      (HBUSREQ),
    .HLOCK        (HLOCK),
    .HTRANS       (HTRANS),
    .HBURST       (HBURST),
    .HREADY       (HREADY),
    .HGRANT       (HGRANT),
    .HMASTER      (HMASTER),
    .HMASTER_DATA (HMASTER_DATA),
    .HMASTLOCK    (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [8*10-1:0] tag;
    logic [N-1:0]    grant;
    logic [W-1:0]    master;
    logic [W-1:0]    mdata;
    logic            lock;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected address/data owners carried between vectors.
  int   e_master = 0;
  int   e_mdata  = 0;

  // Picks the expectation matching the build's arbitration policy.
  function automatic int sel(input int rr, input int fp);
`ifdef AHB_ARB_FIXED_PRIORITY_EN
    return fp;
`else
    return rr;
`endif
  endfunction

  task automatic step(input logic [8*10-1:0] tag, input bit rst, input logic [N-1:0] req,
                      input logic [N-1:0] lock, input logic [1:0] trans, input logic [2:0] burst,
                      input logic rdy, input int exp_m, input logic exp_l);
    exp_t e;
    @(negedge HCLK);
    HRESETn = !rst;
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = rdy;
    if (rst) begin
      e_master = 0;
      e_mdata  = 0;
    end else begin
      if (rdy) e_mdata = e_master;
      e_master = exp_m;
    end
    e.tag    = tag;
    e.grant  = N'(1) << e_master;
    e.master = W'(e_master);
    e.mdata  = W'(e_mdata);
    e.lock   = rst ? 1'b0 : exp_l;
    sb.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge HCLK);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK} !== {e.grant, e.master, e.mdata, e.lock}) begin
        n_err++;
        $display("FAIL %0s: got grant=%b master=%0d data=%0d lock=%b, expected grant=%b master=%0d data=%0d lock=%b",
                 e.tag, HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK, e.grant, e.master, e.mdata, e.lock);
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = SINGLE;
    HREADY  = 1'b1;

    step("reset", 1, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0);
    step("reset", 1, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0);
    for (int k = 0; k < 20; k++)
      step("park", 0, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0);

    // Managers 1 and 2 alternate on SINGLE transfers.
    step("rr_first", 0, 3'b110, 3'b000, IDLE, SINGLE, 1, 1, 0);
    for (int k = 0; k < 5; k++)
      step("rr_alt", 0, 3'b110, 3'b000, NONSEQ, SINGLE, 1, sel((k % 2 == 0) ? 2 : 1, 1), 0);

    // INCR4 by manager 1 holds the bus until its fourth beat is accepted.
    step("to_m1", 0, 3'b010, 3'b000, IDLE, SINGLE, 1, 1, 0);
    step("incr4_b1", 0, 3'b110, 3'b000, NONSEQ, INCR4, 1, 1, 0);
    step("incr4_b2", 0, 3'b110, 3'b000, SEQ, INCR4, 1, 1, 0);
    step("incr4_b3", 0, 3'b110, 3'b000, SEQ, INCR4, 1, 1, 0);
    step("incr4_b4", 0, 3'b110, 3'b000, SEQ, INCR4, 1, sel(2, 1), 0);

    // INCR8 with three wait states mid-burst; counter must hold while HREADY=0.
    step("incr8_b1", 0, 3'b110, 3'b000, NONSEQ, INCR8, 1, sel(2, 1), 0);
    step("incr8_seq", 0, 3'b110, 3'b000, SEQ, INCR8, 1, sel(2, 1), 0);
    step("incr8_seq", 0, 3'b110, 3'b000, SEQ, INCR8, 1, sel(2, 1), 0);
    for (int k = 0; k < 3; k++)
      step("incr8_wait", 0, 3'b111, 3'b000, SEQ, INCR8, 0, sel(2, 1), 0);
    for (int k = 0; k < 4; k++)
      step("incr8_seq", 0, 3'b110, 3'b000, SEQ, INCR8, 1, sel(2, 1), 0);
    step("incr8_last", 0, 3'b110, 3'b000, SEQ, INCR8, 1, 1, 0);

    // A would-be arbitration point frozen by a wait state.
    step("frz_idle", 0, 3'b100, 3'b000, IDLE, SINGLE, 0, 1, 0);

    // Locked sequence by manager 2 with 0 and 1 also requesting.
    step("to_m2", 0, 3'b100, 3'b100, IDLE, SINGLE, 1, 2, 0);
    for (int k = 0; k < 3; k++)
      step("locked", 0, 3'b111, 3'b100, NONSEQ, SINGLE, 1, 2, 1);
    step("unlock_1", 0, 3'b011, 3'b000, IDLE, SINGLE, 1, 2, 0);
    step("unlock_2", 0, 3'b011, 3'b000, IDLE, SINGLE, 1, 0, 0);

    // BUSY never hands over; SEQ of an INCR burst may.
    step("busy", 0, 3'b011, 3'b000, BUSY, INCR, 1, 0, 0);
    step("seq_incr", 0, 3'b011, 3'b000, SEQ, INCR, 1, sel(1, 0), 0);

    // Managers 0 and 2 requesting continuously.
    for (int k = 0; k < 5; k++)
      step("m0_m2", 0, 3'b101, 3'b000, NONSEQ, SINGLE, 1, sel((k % 2 == 0) ? 2 : 0, 0), 0);

    // Reset in the middle of a burst returns to the parked state.
    step("rst_mid", 1, 3'b101, 3'b000, NONSEQ, INCR4, 1, 0, 0);
    step("post_rst", 0, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0);

    @(negedge HCLK);
    @(negedge HCLK);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
